pipe_ctrl: RTL

Pipeline sequencing controller for the five-stage MiniSys core (IF, ID, EX, MEM, WB). It collects hazard and redirect requests from ID, EX and MEM. It drives a hold (stall) vector and a bubble/redirect (flush) vector to the PC register and to the if_id, id_ex, ex_mem and mem_wb pipeline registers. It also owns the multi-cycle divider stall window, using an internal state machine and down-counter.

---
 rtl/pipe_pkg.sv | 38 +++
 rtl/pipe_ctrl_div_window.sv | 80 ++++++++
 rtl/pipe_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MiniSys pipeline sequencing controller:
// stage indices, divider FSM states, exception vector and small helpers.
package pipe_pkg;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;
    localparam int NUM_STG   = 5;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_BUSY = 2'd1,
        ST_DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    // Builds a per-stage control vector so bit positions come from the stage indices.
    function automatic logic [NUM_STG-1:0] stage_mask(input logic pc, input logic ifid,
                                                      input logic idex, input logic exmem,
                                                      input logic memwb);
        logic [NUM_STG-1:0] m;
        m            = {NUM_STG{1'b0}};
        m[STG_PC]    = pc;
        m[STG_IFID]  = ifid;
        m[STG_IDEX]  = idex;
        m[STG_EXMEM] = exmem;
        m[STG_MEMWB] = memwb;
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_div_window.sv
// Divider stall window: a three-state FSM with a down-counter that keeps EX
// held for DIV_CYCLES cycles and then pulses div_done for one cycle.
module pipe_ctrl_div_window
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic div_start_i,
    input  logic exc_i,
    output logic in_window_o,
    output logic div_busy_o,
    output logic div_done_o
);

    localparam int               CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state and counter logic; an exception aborts the window from any state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exc_i) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (div_start_i) begin
                        state_d = ST_DIV_BUSY;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                end
                ST_DIV_BUSY: begin
                    if (cnt_q == CNT_ZERO) begin
                        state_d = ST_DIV_DONE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_DIV_BUSY;
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                // The div that triggered the window is still in EX here, so its start is ignored.
                ST_DIV_DONE: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign div_busy_o  = (state_q == ST_DIV_BUSY);
    assign div_done_o  = (state_q == ST_DIV_DONE);
    assign in_window_o = div_busy_o | ((state_q == ST_IDLE) & div_start_i);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: prioritises exception, divider, load-use and
// branch requests into hold/bubble vectors and counts PC-stall cycles.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int          DIV_CYCLES = 32,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        branch_id,
    input  logic        div_start_ex,
    input  logic        exc_mem,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic [31:0] exc_pc,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] stall_cnt
);

    logic        in_window_s;
    logic [4:0]  stall_s, flush_s;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    pipe_ctrl_div_window #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div_window (
        .clk_i      (clk),
        .rst_i      (rst),
        .div_start_i(div_start_ex),
        .exc_i      (exc_mem),
        .in_window_o(in_window_s),
        .div_busy_o (div_busy),
        .div_done_o (div_done)
    );

    // Fixed-priority request encoder; lower-priority requests are simply dropped.
    always_comb begin
        stall_s = 5'b00000;
        flush_s = 5'b00000;
        if (rst) begin
            stall_s = 5'b00000;
            flush_s = 5'b00000;
        end else if (exc_mem) begin
            stall_s = stage_mask(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            flush_s = stage_mask(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        end else if (in_window_s) begin
            stall_s = stage_mask(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            flush_s = stage_mask(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end else if (stallreq_id) begin
            stall_s = stage_mask(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            flush_s = stage_mask(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end else if (branch_id) begin
            stall_s = stage_mask(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            flush_s = stage_mask(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end else begin
            stall_s = 5'b00000;
            flush_s = 5'b00000;
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        if (stall_s[STG_PC]) begin
            stall_cnt_d = sat_inc32(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall-counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'h0000_0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall     = stall_s;
    assign flush     = flush_s;
    assign exc_pc    = flush_s[STG_PC] ? EXC_VECTOR : 32'h0000_0000;
    assign stall_cnt = stall_cnt_q;

endmodule
